cic_post_proc: RTL

- Sits directly downstream of the CIC decimator. It consumes the 32-bit `out` word each time the decimator pulses `out_rdy`.
- Processing chain, in order:
  - programmable arithmetic right shift to remove the CIC bit growth;
  - optional first-order DC-removal (leaky integrator);
  - saturation to 16-bit signed.
- Results are buffered in a first-word-fall-through FIFO, which is drained by the downstream consumer (correlator / host interface).

---
 rtl/cic_post_proc.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cic_post_proc.sv
// Post-processing for the CIC decimator output: gain shift, optional DC removal,
// saturation to OW bits, and a first-word-fall-through output FIFO.
module cic_post_proc #(
    parameter int DW         = 32,
    parameter int OW         = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int DC_K       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         din,
    input  logic                  din_rdy,
    input  logic [4:0]            shift,
    input  logic                  dc_en,
    input  logic                  rd_en,
    input  logic                  clr_flags,
    output logic [OW-1:0]         dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  sat
);

    localparam int AW    = DW + DC_K;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Stage 1: shifted sample plus the DC-enable that travels with it.
    logic signed [DW-1:0] s1;
    logic                 v1;
    logic                 en1;

    // NOTE: every clocked register is assigned with <=, so all of them see the
    // pre-edge values of each other regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= '0;
            v1  <= 1'b0;
            en1 <= 1'b0;
        end else begin
            v1 <= din_rdy;
            if (din_rdy) begin
                s1  <= $signed(din) >>> shift;
                en1 <= dc_en;
            end
        end
    end

    // Stage 2: leaky-integrator DC estimate; dc is acc >>> DC_K truncated to DW bits.
    logic signed [AW-1:0] acc;
    logic        [DW-1:0] dc;
    logic        [DW:0]   diff;
    logic        [DW:0]   x;
    logic        [AW-1:0] acc_next;
    logic [DW-OW+1:0]     hi_bits;
    logic                 clip;
    logic        [OW-1:0] y;

    assign dc       = acc[AW-1:DC_K];
    assign diff     = {s1[DW-1], s1} - {dc[DW-1], dc};
    assign x        = en1 ? diff : {s1[DW-1], s1};
    assign acc_next = acc + {{(DC_K-1){diff[DW]}}, diff};
    assign hi_bits  = x[DW:OW-1];

    // NOTE: y gets a value on every path (default first), so no latch is inferred.
    always_comb begin
        y    = x[OW-1:0];
        clip = !((&hi_bits) || !(|hi_bits));
        if (clip) begin
            y = x[DW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (!dc_en) begin
            acc <= '0;
        end else if (v1) begin
            acc <= en1 ? $signed(acc_next) : '0;
        end
    end

    // FIFO control: a write while full is still accepted when a pop frees the slot.
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [OW-1:0]         mem [DEPTH];

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign pop   = rd_en && !empty;
    assign push  = v1 && (!full || rd_en);
    assign drop  = v1 && full && !rd_en;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; dout is forced to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            sat      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            overflow <= (overflow && !clr_flags) || drop;
            sat      <= (sat && !clr_flags) || (v1 && clip);
        end
    end

endmodule
